// File: rtl/arb_mux2_if.sv
// arb_mux2_if - handshake and status bundle for the two-source arbiter/mux.
//
// Signals:
//   valid0/data_in0/ready0  source 0 valid/ready channel
//   valid1/data_in1/ready1  source 1 valid/ready channel
//   selector                registered mux select (0 = source 0, 1 = source 1)
//   data_out/valid_out      one-deep output stage toward the consumer
//   ready_out               consumer acceptance of data_out
//   grant_count0/1          per-source transfer counters (wrapping)
//
// Modports:
//   slave   the arbiter side (drives ready*, selector, output stage, counters)
//   master  the sources/consumer side (drives valid*, data_in*, ready_out)

interface arb_mux2_if #(
    parameter int DATA_WIDTH = 2,
    parameter int CNT_WIDTH  = 5
) ();

    logic                  valid0;
    logic [DATA_WIDTH-1:0] data_in0;
    logic                  ready0;

    logic                  valid1;
    logic [DATA_WIDTH-1:0] data_in1;
    logic                  ready1;

    logic                  selector;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_out;

    logic [CNT_WIDTH-1:0]  grant_count0;
    logic [CNT_WIDTH-1:0]  grant_count1;

    modport slave (
        input  valid0, data_in0, valid1, data_in1, ready_out,
        output ready0, ready1, selector, data_out, valid_out,
               grant_count0, grant_count1
    );

    modport master (
        output valid0, data_in0, valid1, data_in1, ready_out,
        input  ready0, ready1, selector, data_out, valid_out,
               grant_count0, grant_count1
    );

endinterface

// File: rtl/arb_mux2.sv
// arb_mux2 - two-requester arbiter and sequencer for a 2:1 data mux.
//
// Grants at most one of two valid/ready sources per cycle, registers the
// selected word and the mux select into a one-deep output stage, and counts
// transfers per source.
//
// Ports:
//   clk     single clock, all state updates on the rising edge
//   reset   synchronous active-high reset
//   bus     arb_mux2_if.slave: source channels, output stage, grant counters
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> contention goes to the source not granted
//                                    last (alternating grants)
//                       undefined -> fixed priority, source 0 wins contention;
//                                    last_grant is still tracked but unused
//
// FSM states:
//   state | meaning
//   ------+-------------------------------------------
//   IDLE  | output stage empty
//   SERV0 | output stage holds a word from source 0
//   SERV1 | output stage holds a word from source 1

module arb_mux2 #(
    parameter int DATA_WIDTH = 2,
    parameter int CNT_WIDTH  = 5
) (
    input  logic       clk,
    input  logic       reset,
    arb_mux2_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERV0 = 2'd1,
        SERV1 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sel_q, sel_d;
    logic                  last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;

    logic slot_free;
    logic any_valid;
    logic winner;
    logic ready0;
    logic ready1;
    logic xfer0;
    logic xfer1;

    // Arbitration and handshake. ready_i depends only on valid inputs,
    // ready_out and registered state, never on itself.
    always_comb begin
        slot_free = (state_q == IDLE) || bus.ready_out;
        any_valid = bus.valid0 || bus.valid1;
        winner    = 1'b0;
        if (bus.valid0 && bus.valid1) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = ~last_grant_q;
`else
            winner = 1'b0;
`endif
        end else if (bus.valid1) begin
            winner = 1'b1;
        end

        // Gated by reset so neither source sees a grant while reset is high.
        ready0 = ~reset && slot_free && any_valid && ~winner;
        ready1 = ~reset && slot_free && any_valid &&  winner;
        xfer0  = bus.valid0 && ready0;
        xfer1  = bus.valid1 && ready1;
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;

        if (xfer0) begin
            state_d      = SERV0;
            data_d       = bus.data_in0;
            sel_d        = 1'b0;
            last_grant_d = 1'b0;
            cnt0_d       = cnt0_q + CNT_WIDTH'(1);
        end else if (xfer1) begin
            state_d      = SERV1;
            data_d       = bus.data_in1;
            sel_d        = 1'b1;
            last_grant_d = 1'b1;
            cnt1_d       = cnt1_q + CNT_WIDTH'(1);
        end else if (bus.ready_out && (state_q != IDLE)) begin
            // Consumer took the word and nothing replaces it.
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            data_q       <= '0;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;   // source 0 wins the first contention
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign bus.ready0       = ready0;
    assign bus.ready1       = ready1;
    assign bus.selector     = sel_q;
    assign bus.data_out     = data_q;
    assign bus.valid_out    = (state_q != IDLE);
    assign bus.grant_count0 = cnt0_q;
    assign bus.grant_count1 = cnt1_q;

endmodule

// File: tb/tb_arb_mux2.sv
// tb_arb_mux2 - self-checking bench for arb_mux2.
// Expected output words come from a small behavioural model and are queued
// when a transfer is driven; words the DUT hands to the consumer are queued
// separately and matched in order. Honours ARB_ROUND_ROBIN_EN like the design.

module tb_arb_mux2;

    localparam int DW = 2;
    localparam int CW = 5;

    logic clk;
    logic reset;

    arb_mux2_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    arb_mux2 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    logic          m_busy;
    logic          m_lg;
    logic [CW-1:0] m_cnt0;
    logic [CW-1:0] m_cnt1;

    logic [DW:0] exp_q[$];   // {selector, data} expected, in transfer order
    logic [DW:0] got_q[$];   // {selector, data} seen at consumption

    // {ready1, ready0} expected from the model for the current inputs.
    function automatic logic [1:0] model_ready();
        logic free;
        logic w;
        if (reset) return 2'b00;
        free = !m_busy || bus.ready_out;
        if (!free || !(bus.valid0 || bus.valid1)) return 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
        w = (bus.valid0 && bus.valid1) ? !m_lg : !bus.valid0;
`else
        w = !bus.valid0;
`endif
        return w ? 2'b10 : 2'b01;
    endfunction

    // One clock: update model, record DUT consumption, advance past the edge.
    task automatic tick();
        logic [1:0] r;
        r = model_ready();
        if (!reset && bus.valid_out && bus.ready_out)
            got_q.push_back({bus.selector, bus.data_out});
        if (reset) begin
            if (m_busy) void'(exp_q.pop_back());
            m_busy = 1'b0;
            m_lg   = 1'b1;
            m_cnt0 = '0;
            m_cnt1 = '0;
        end else if (r[0] && bus.valid0) begin
            exp_q.push_back({1'b0, bus.data_in0});
            m_busy = 1'b1;
            m_lg   = 1'b0;
            m_cnt0 = m_cnt0 + 1'b1;
        end else if (r[1] && bus.valid1) begin
            exp_q.push_back({1'b1, bus.data_in1});
            m_busy = 1'b1;
            m_lg   = 1'b1;
            m_cnt1 = m_cnt1 + 1'b1;
        end else if (bus.ready_out) begin
            m_busy = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [DW-1:0] d0,
                         input logic v1, input logic [DW-1:0] d1,
                         input logic ro);
        bus.valid0    = v0;
        bus.data_in0  = d0;
        bus.valid1    = v1;
        bus.data_in1  = d1;
        bus.ready_out = ro;
        #1;
    endtask

    task automatic flush();
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m_busy = 1'b0;
        drive(1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
        tick();
        tick();
        n_tests++;
        if (bus.ready0 !== 1'b0 || bus.ready1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b%b expected 00", bus.ready1, bus.ready0);
        end
        n_tests++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== 2'b00 || bus.selector !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b d=%b s=%b expected v=0 d=00 s=0",
                     bus.valid_out, bus.data_out, bus.selector);
        end
        n_tests++;
        if (bus.grant_count0 !== 5'd0 || bus.grant_count1 !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", bus.grant_count0, bus.grant_count1);
        end
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        #1;
        n_tests++;
        if (bus.ready0 !== 1'b1 || bus.ready1 !== 1'b0) begin
            n_fail++;
            $display("FAIL first_grant: got r1r0=%b%b expected 01", bus.ready1, bus.ready0);
        end
        tick();
        n_tests++;
        if (bus.selector !== 1'b0 || bus.data_out !== 2'b01 || bus.valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL first_word: got s=%b d=%b v=%b expected s=0 d=01 v=1",
                     bus.selector, bus.data_out, bus.valid_out);
        end
        flush();
    endtask

    task automatic test_single();
        logic [DW:0] g, e;
        do_reset();
        drive(1'b1, 2'b11, 1'b0, 2'b00, 1'b1);
        n_tests++;
        if (bus.ready0 !== 1'b1 || bus.ready1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready: got r1r0=%b%b expected 01", bus.ready1, bus.ready0);
        end
        tick();
        n_tests++;
        if (bus.data_out !== 2'b11 || bus.selector !== 1'b0 || bus.valid_out !== 1'b1
            || bus.grant_count0 !== 5'd1) begin
            n_fail++;
            $display("FAIL single_word: got d=%b s=%b v=%b c0=%0d expected d=11 s=0 v=1 c0=1",
                     bus.data_out, bus.selector, bus.valid_out, bus.grant_count0);
        end
        flush();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL single_sb_count: got %0d words expected %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL single_sb: got %b expected %b", g, e);
            end
        end
    endtask

    task automatic test_contention();
        logic [DW-1:0] exp_d[4];
        logic          exp_s[4];
        logic [CW-1:0] exp_c0, exp_c1;
        logic [DW:0]   g, e;
`ifdef ARB_ROUND_ROBIN_EN
        exp_d  = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_s  = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_c0 = 5'd2;
        exp_c1 = 5'd2;
`else
        exp_d  = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_s  = '{1'b0, 1'b0, 1'b0, 1'b0};
        exp_c0 = 5'd4;
        exp_c1 = 5'd0;
`endif
        do_reset();
        drive(1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (bus.data_out !== exp_d[i] || bus.selector !== exp_s[i]) begin
                n_fail++;
                $display("FAIL contention[%0d]: got d=%b s=%b expected d=%b s=%b",
                         i, bus.data_out, bus.selector, exp_d[i], exp_s[i]);
            end
        end
        n_tests++;
        if (bus.grant_count0 !== exp_c0 || bus.grant_count1 !== exp_c1) begin
            n_fail++;
            $display("FAIL contention_cnt: got %0d/%0d expected %0d/%0d",
                     bus.grant_count0, bus.grant_count1, exp_c0, exp_c1);
        end
        flush();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL contention_sb_count: got %0d words expected %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL contention_sb: got %b expected %b", g, e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]    exp_r;
        logic [DW-1:0] exp_d;
        logic          exp_s;
        logic [DW:0]   g, e;
`ifdef ARB_ROUND_ROBIN_EN
        exp_r = 2'b10;
        exp_d = 2'b11;
        exp_s = 1'b1;
`else
        exp_r = 2'b01;
        exp_d = 2'b01;
        exp_s = 1'b0;
`endif
        do_reset();
        drive(1'b1, 2'b10, 1'b0, 2'b00, 1'b1);
        tick();
        drive(1'b1, 2'b01, 1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (bus.ready0 !== 1'b0 || bus.ready1 !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: got r1r0=%b%b expected 00", i, bus.ready1, bus.ready0);
            end
            tick();
            n_tests++;
            if (bus.data_out !== 2'b10 || bus.selector !== 1'b0 || bus.valid_out !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got d=%b s=%b v=%b expected d=10 s=0 v=1",
                         i, bus.data_out, bus.selector, bus.valid_out);
            end
        end
        bus.ready_out = 1'b1;
        #1;
        n_tests++;
        if ({bus.ready1, bus.ready0} !== exp_r) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b%b expected %b", bus.ready1, bus.ready0, exp_r);
        end
        tick();
        n_tests++;
        if (bus.data_out !== exp_d || bus.selector !== exp_s || bus.valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_replace: got d=%b s=%b v=%b expected d=%b s=%b v=1",
                     bus.data_out, bus.selector, bus.valid_out, exp_d, exp_s);
        end
        flush();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_sb_count: got %0d words expected %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL bp_sb: got %b expected %b", g, e);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 2'b01, 1'b0, 2'b00, 1'b1);
        tick();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 2'b00, 1'b1, DW'(i), 1'b1);
            tick();
            if (i == 30) begin
                n_tests++;
                if (bus.grant_count1 !== 5'd31) begin
                    n_fail++;
                    $display("FAIL wrap_pre: got %0d expected 31", bus.grant_count1);
                end
            end
        end
        n_tests++;
        if (bus.grant_count1 !== 5'd0 || bus.grant_count0 !== 5'd1) begin
            n_fail++;
            $display("FAIL wrap: got c1=%0d c0=%0d expected c1=0 c0=1",
                     bus.grant_count1, bus.grant_count0);
        end
        n_tests++;
        if (bus.data_out !== 2'b11 || bus.selector !== 1'b1 || bus.valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_word: got d=%b s=%b v=%b expected d=11 s=1 v=1",
                     bus.data_out, bus.selector, bus.valid_out);
        end
        flush();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 2'b11, 1'b0, 2'b00, 1'b1);
        tick();
        drive(1'b1, 2'b10, 1'b1, 2'b01, 1'b0);
        tick();
        n_tests++;
        if (bus.valid_out !== 1'b1 || bus.grant_count0 !== 5'd1) begin
            n_fail++;
            $display("FAIL mid_pre: got v=%b c0=%0d expected v=1 c0=1", bus.valid_out, bus.grant_count0);
        end
        reset = 1'b1;
        #1;
        tick();
        n_tests++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== 2'b00 || bus.grant_count0 !== 5'd0
            || bus.grant_count1 !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b d=%b c0=%0d c1=%0d expected v=0 d=00 c0=0 c1=0",
                     bus.valid_out, bus.data_out, bus.grant_count0, bus.grant_count1);
        end
        n_tests++;
        if (bus.ready0 !== 1'b0 || bus.ready1 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ready: got r1r0=%b%b expected 00", bus.ready1, bus.ready0);
        end
        reset = 1'b0;
        flush();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [1:0]  r;
        logic [DW:0] g, e;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), DW'($urandom),
                  1'($urandom_range(0, 1)), DW'($urandom),
                  ($urandom_range(0, 3) != 0));
            r = model_ready();
            n_tests++;
            if ({bus.ready1, bus.ready0} !== r) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b%b expected %b", i, bus.ready1, bus.ready0, r);
            end
            tick();
            n_tests++;
            if (bus.valid_out !== m_busy || bus.grant_count0 !== m_cnt0 || bus.grant_count1 !== m_cnt1) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got v=%b c0=%0d c1=%0d expected v=%b c0=%0d c1=%0d",
                         i, bus.valid_out, bus.grant_count0, bus.grant_count1, m_busy, m_cnt0, m_cnt1);
            end
        end
        flush();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_sb_count: got %0d words expected %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL rand_sb: got %b expected %b", g, e);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        m_busy = 1'b0;
        m_lg   = 1'b1;
        m_cnt0 = '0;
        m_cnt1 = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_mux2.md
# arb_mux2

Two-requester arbiter and sequencer for the 2:1 data multiplexer. It accepts words from two independent valid/ready sources and grants one source per cycle. It drives the mux `selector` and registers the selected word into a one-deep output stage with a valid/ready handshake toward the consumer. It also keeps per-source grant counters, which the benches compare against the behavioural and structural mux models.

## Interface
- `DATA_WIDTH`, default 2: width of each data word.
- `CNT_WIDTH`, default 5: width of each grant counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `valid0`  in  1  source 0 has a word on `data_in0`.
- `data_in0`  in  DATA_WIDTH  source 0 word.
- `ready0`  out  1  source 0 word is taken this cycle.
- `valid1`  in  1  source 1 has a word on `data_in1`.
- `data_in1`  in  DATA_WIDTH  source 1 word.
- `ready1`  out  1  source 1 word is taken this cycle.
- `selector`  out  1  mux select; 0 = source 0, 1 = source 1; registered.
- `data_out`  out  DATA_WIDTH  registered selected word.
- `valid_out`  out  1  `data_out` holds an unconsumed word.
- `ready_out`  in  1  consumer takes `data_out` this cycle.
- `grant_count0`  out  CNT_WIDTH  number of source 0 transfers, modulo 2^CNT_WIDTH.
- `grant_count1`  out  CNT_WIDTH  number of source 1 transfers, modulo 2^CNT_WIDTH.

## Operation
- The FSM has three states:
  - IDLE: output stage empty.
  - SERV0: output stage holds a source 0 word.
  - SERV1: output stage holds a source 1 word.
- `slot_free = (state == IDLE) || ready_out`.
- Choice of winner:
  - Only one `valid_i` high: that source wins.
  - Both high: the source not granted last wins (`last_grant` register).
  - Neither high: no winner.
- `ready_i` is combinational: `ready_i = slot_free && winner == i`. At most one `ready_i` is high in any cycle. `ready_i` never depends on `ready_i` itself, which prevents combinational loops.
- On a transfer (`valid_i && ready_i` at the rising edge):
  - `data_out <= data_in_i`, `selector <= i`, `last_grant <= i`.
  - `grant_count_i <= grant_count_i + 1`, wrapping from 2^CNT_WIDTH-1 to 0.
  - The state moves to SERV_i.
- When `ready_out` is high, there is no transfer, and state ≠ IDLE, the state moves to IDLE.
- In every other case all registers hold their values. While `valid_out=1 && ready_out=0`, `data_out` and `selector` are stable.
- `valid_out = (state != IDLE)`.
- A source may drop `valid_i` without being granted; no penalty.

## Timing
- Reset values (applied at the first rising edge with `reset=1`):
  - state = IDLE, `valid_out` = 0, `data_out` = 0, `selector` = 0.
  - `last_grant` = 1, so source 0 wins the first contention.
  - `grant_count0` = `grant_count1` = 0.
  - `ready0` = `ready1` = 0 while `reset` is high.
- Latency: a word accepted at edge N is visible on `data_out`/`valid_out` after edge N.
- Throughput: one word per cycle while `ready_out` stays high. Back-to-back transfers are allowed: consumption and a new accept happen on the same edge.
- Both sources held valid with `ready_out=1` gives grants 0,1,0,1,…
- Reset asserted mid-transfer wins over everything. The pending output word is discarded and the counters clear.
- A counter wrap has no side effects.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: contention follows the round-robin rule above.
- Undefined: fixed priority, where source 0 always wins contention. `last_grant` is still updated but ignored. All other behaviour is identical.

## Test plan
- Reset with `valid0=valid1=1` → `ready0=ready1=0`, `valid_out=0`, `data_out=2'b00`, counters 0. After release, the first grant goes to source 0.
- `valid0=1`, `data_in0=2'b11`, `ready_out=1`, `valid1=0` → `ready0=1`. Next cycle: `data_out=2'b11`, `selector=0`, `valid_out=1`, `grant_count0=1`.
- Both valid, `data_in0=2'b01`, `data_in1=2'b10`, `ready_out=1`, 4 cycles:
  - With `ARB_ROUND_ROBIN_EN`: `data_out` sequence 01,10,01,10 and `selector` 0,1,0,1; each counter = 2.
  - Without it: four 01 words, `grant_count0=4`, `grant_count1=0`.
- Backpressure: transfer a word, then hold `ready_out=0` for 3 cycles with both valid → `ready0=ready1=0`; `data_out` and `selector` stay constant. Raise `ready_out` → the consumed word is replaced on the same edge.
- 32 transfers from source 1 → `grant_count1` wraps 31→0 and `grant_count0` is unchanged.
- Assert `reset` for one cycle while `valid_out=1` and `ready_out=0` → after that edge: `valid_out=0`, state IDLE, counters 0.
